// File: rtl/regfile_scb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scb_if
// Brief    : Read, write, allocate and dump signal bundle for regfile_scb.
// Revision : 1.0
// ============================================================================
interface regfile_scb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NB_RD_PORTS = 2
);
    logic [NB_RD_PORTS*ADDR_WIDTH-1:0] i_raddr;
    logic [NB_RD_PORTS*DATA_WIDTH-1:0] o_rdata;
    logic [NB_RD_PORTS-1:0]            o_rpend;
    logic                              i_wen;
    logic [ADDR_WIDTH-1:0]             i_waddr;
    logic [DATA_WIDTH-1:0]             i_wdata;
    logic                              i_alloc;
    logic [ADDR_WIDTH-1:0]             i_alloc_addr;
    logic                              i_dump_start;
    logic                              o_dump_valid;
    logic                              i_dump_ready;
    logic [ADDR_WIDTH-1:0]             o_dump_addr;
    logic [DATA_WIDTH-1:0]             o_dump_data;
    logic                              o_dump_done;

    modport slave (
        input  i_raddr, i_wen, i_waddr, i_wdata, i_alloc, i_alloc_addr,
               i_dump_start, i_dump_ready,
        output o_rdata, o_rpend, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
    );

    modport master (
        output i_raddr, i_wen, i_waddr, i_wdata, i_alloc, i_alloc_addr,
               i_dump_start, i_dump_ready,
        input  o_rdata, o_rpend, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scb
// Brief    : Multi-read-port register file with write bypass, pending-write
//            scoreboard and a handshaked sequential dump port.
// Revision : 1.0
// ============================================================================
module regfile_scb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NB_RD_PORTS = 2,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit BYPASS      = 1'b1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    regfile_scb_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB_LK = NB_RD_PORTS + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    logic [DATA_WIDTH-1:0]             regs_q [DEPTH];
    logic [DEPTH-1:0]                  pend_q, pend_d;
    state_e                            state_q, state_d;
    logic [ADDR_WIDTH-1:0]             cnt_q, cnt_d;
    logic                              w_dump_valid, w_dump_done;
    logic                              w_wr_ok;
    logic [ADDR_WIDTH-1:0]             w_lk_addr [NB_LK];
    logic [DATA_WIDTH-1:0]             w_lk_data [NB_LK];
    logic [NB_RD_PORTS*DATA_WIDTH-1:0] w_rdata;
    logic [NB_RD_PORTS-1:0]            w_rpend;

    assign w_wr_ok = bus.i_wen && !(ZERO_REG && (bus.i_waddr == '0));

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[bus.i_waddr] <= bus.i_wdata;
        end
    end

    // Alloc is applied after the clear so a new producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.i_wen && (bus.i_waddr == ADDR_WIDTH'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (bus.i_alloc && (bus.i_alloc_addr == ADDR_WIDTH'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Lookup slots 0..NB_RD_PORTS-1 serve the read ports; the last serves the dump port.
    for (genvar k = 0; k < NB_RD_PORTS; k++) begin : g_rd
        assign w_lk_addr[k]                          = bus.i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rdata[k*DATA_WIDTH +: DATA_WIDTH]   = w_lk_data[k];
        assign w_rpend[k]                            = pend_q[w_lk_addr[k]];
    end

    assign w_lk_addr[NB_RD_PORTS] = cnt_q;

    for (genvar k = 0; k < NB_LK; k++) begin : g_lk
        assign w_lk_data[k] =
            (ZERO_REG && (w_lk_addr[k] == '0))                    ? '0          :
            (BYPASS && bus.i_wen && (bus.i_waddr == w_lk_addr[k])) ? bus.i_wdata :
                                                                     regs_q[w_lk_addr[k]];
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_dump_valid = 1'b0;
        w_dump_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_dump_start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                w_dump_valid = 1'b1;
                if (bus.i_dump_ready) begin
                    if (&cnt_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_dump_done = 1'b1;
                cnt_d       = '0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_rdata      = w_rdata;
    assign bus.o_rpend      = w_rpend;
    assign bus.o_dump_valid = w_dump_valid;
    assign bus.o_dump_done  = w_dump_done;
    assign bus.o_dump_addr  = cnt_q;
    assign bus.o_dump_data  = w_lk_data[NB_RD_PORTS];
endmodule
`default_nettype wire

// File: tb/tb_regfile_scb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scb
// Brief    : Scoreboard bench for regfile_scb, bypass and no-bypass instances.
// Revision : 1.0
// ============================================================================
module tb_regfile_scb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_RD_PORTS(NP)) bus ();
    regfile_scb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_RD_PORTS(NP)) bus_nb ();

    regfile_scb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_RD_PORTS(NP),
                  .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk(clk), .i_rst_n(rst_n), .bus(bus));

    regfile_scb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_RD_PORTS(NP),
                  .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .i_rst_n(rst_n), .bus(bus_nb));

    assign bus_nb.i_raddr      = bus.i_raddr;
    assign bus_nb.i_wen        = bus.i_wen;
    assign bus_nb.i_waddr      = bus.i_waddr;
    assign bus_nb.i_wdata      = bus.i_wdata;
    assign bus_nb.i_alloc      = bus.i_alloc;
    assign bus_nb.i_alloc_addr = bus.i_alloc_addr;
    assign bus_nb.i_dump_start = 1'b0;
    assign bus_nb.i_dump_ready = 1'b0;

    typedef struct { string name; int sel; logic [31:0] exp; } rexp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } dexp_t;

    rexp_t rd_q[$];
    dexp_t dump_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int last_beat_cyc = -10;
    int done_cyc      = -20;
    event chk_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return bus.o_rdata[31:0];
            1:       return bus.o_rdata[63:32];
            2:       return bus_nb.o_rdata[31:0];
            3:       return {31'b0, bus.o_rpend[0]};
            4:       return {31'b0, bus.o_rpend[1]};
            5:       return {31'b0, bus.o_dump_valid};
            6:       return {31'b0, bus.o_dump_done};
            default: return {27'b0, bus.o_dump_addr};
        endcase
    endfunction

    task automatic drain();
        rexp_t e;
        while (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check(e.name, sample(e.sel), e.exp);
        end
    endtask

    always @(negedge clk) begin
        dexp_t d;
        drain();
        if (bus.o_dump_valid && bus.i_dump_ready) begin
            if (dump_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dump_unexpected_beat: got addr %0d expected no beat", bus.o_dump_addr);
            end else begin
                d = dump_q.pop_front();
                check("dump_addr", {27'b0, bus.o_dump_addr}, {27'b0, d.addr});
                check("dump_data", bus.o_dump_data, d.data);
            end
            beats++;
            last_beat_cyc = cyc;
        end
        if (bus.o_dump_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    always @(chk_ev) drain();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string n, input int s, input logic [31:0] e);
        rd_q.push_back('{name: n, sel: s, exp: e});
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.i_raddr = {a1, a0};
    endtask

    int base_beats, base_done;

    initial begin
        bus.i_raddr      = '0;
        bus.i_wen        = 1'b0;
        bus.i_waddr      = '0;
        bus.i_wdata      = '0;
        bus.i_alloc      = 1'b0;
        bus.i_alloc_addr = '0;
        bus.i_dump_start = 1'b0;
        bus.i_dump_ready = 1'b0;

        #2;
        expect_rd("reset_rdata0", 0, 32'h0);
        expect_rd("reset_rpend0", 3, 32'h0);
        expect_rd("reset_dump_valid", 5, 32'h0);
        expect_rd("reset_dump_done", 6, 32'h0);
        expect_rd("reset_dump_addr", 7, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic write then read
        bus.i_wen = 1'b1; bus.i_waddr = 5'd5; bus.i_wdata = 32'hDEADBEEF;
        tick();
        bus.i_wen = 1'b0;
        set_rd(5'd5, 5'd0);
        expect_rd("read_x5", 0, 32'hDEADBEEF);
        expect_rd("read_x0_port1", 1, 32'h0);
        expect_rd("nb_read_x5", 2, 32'hDEADBEEF);

        // Same-cycle write and read
        tick();
        bus.i_wen = 1'b1; bus.i_waddr = 5'd7; bus.i_wdata = 32'h12345678;
        set_rd(5'd7, 5'd0);
        expect_rd("bypass_x7", 0, 32'h12345678);
        expect_rd("nobypass_x7_old", 2, 32'h0);
        tick();
        bus.i_wen = 1'b0;
        expect_rd("read_x7_after", 0, 32'h12345678);
        expect_rd("nb_read_x7_after", 2, 32'h12345678);

        // Register zero
        tick();
        bus.i_wen = 1'b1; bus.i_waddr = 5'd0; bus.i_wdata = 32'hFFFFFFFF;
        bus.i_alloc = 1'b1; bus.i_alloc_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        expect_rd("x0_same_cycle", 0, 32'h0);
        tick();
        bus.i_wen = 1'b0; bus.i_alloc = 1'b0;
        expect_rd("x0_read", 0, 32'h0);
        expect_rd("x0_rpend", 3, 32'h0);

        // Scoreboard
        tick();
        bus.i_alloc = 1'b1; bus.i_alloc_addr = 5'd3;
        set_rd(5'd3, 5'd3);
        expect_rd("rpend_not_bypassed", 3, 32'h0);
        tick();
        bus.i_alloc = 1'b0;
        expect_rd("rpend_after_alloc", 3, 32'h1);
        expect_rd("rpend_after_alloc_p1", 4, 32'h1);
        tick();
        bus.i_wen = 1'b1; bus.i_waddr = 5'd3; bus.i_wdata = 32'd33;
        expect_rd("rpend_during_write", 3, 32'h1);
        tick();
        bus.i_wen = 1'b0;
        expect_rd("rpend_cleared", 3, 32'h0);
        tick();
        bus.i_alloc = 1'b1; bus.i_alloc_addr = 5'd3;
        bus.i_wen = 1'b1; bus.i_waddr = 5'd3; bus.i_wdata = 32'd34;
        tick();
        bus.i_alloc = 1'b0; bus.i_wen = 1'b0;
        expect_rd("rpend_set_wins", 3, 32'h1);
        expect_rd("rpend_set_wins_p1", 4, 32'h1);
        expect_rd("x3_written", 0, 32'd34);

        // Fill xi = i
        for (int i = 1; i < 32; i++) begin
            tick();
            bus.i_wen = 1'b1; bus.i_waddr = AW'(i); bus.i_wdata = 32'(i);
        end
        tick();
        bus.i_wen = 1'b0;
        set_rd(5'd3, 5'd31);
        expect_rd("rpend_cleared_by_fill", 3, 32'h0);
        expect_rd("read_x31", 1, 32'd31);

        // Full dump with toggling ready and an ignored start during RUN
        for (int i = 0; i < 32; i++) dump_q.push_back('{addr: AW'(i), data: 32'(i)});
        base_beats = beats;
        base_done  = done_cnt;
        tick();
        bus.i_dump_start = 1'b1; bus.i_dump_ready = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 200 && done_cnt == base_done; c++) begin
            tick();
            bus.i_dump_ready = ~bus.i_dump_ready;
            bus.i_dump_start = (c == 5);
        end
        bus.i_dump_ready = 1'b0;
        bus.i_dump_start = 1'b0;
        check("dump_beats", 32'(beats - base_beats), 32'd32);
        check("dump_done_count", 32'(done_cnt - base_done), 32'd1);
        check("done_after_last_beat", 32'(done_cyc), 32'(last_beat_cyc + 1));
        check("dump_queue_empty", 32'(dump_q.size()), 32'd0);
        tick(); tick(); tick();
        check("no_queued_dump", 32'(done_cnt - base_done), 32'd1);
        expect_rd("idle_valid_low", 5, 32'h0);
        expect_rd("idle_dump_addr", 7, 32'h0);

        // Reset in the middle of a dump
        tick();
        bus.i_alloc = 1'b1; bus.i_alloc_addr = 5'd9;
        tick();
        bus.i_alloc = 1'b0;
        set_rd(5'd5, 5'd9);
        expect_rd("rpend_x9_pre_reset", 4, 32'h1);
        for (int i = 0; i < 10; i++) dump_q.push_back('{addr: AW'(i), data: 32'(i)});
        base_beats = beats;
        base_done  = done_cnt;
        tick();
        bus.i_dump_start = 1'b1; bus.i_dump_ready = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 100 && beats < base_beats + 10; c++) begin
            @(negedge clk);
            #1;
        end
        check("beats_before_reset", 32'(beats - base_beats), 32'd10);
        tick();
        rst_n = 1'b0;
        #1;
        expect_rd("valid_async_drop", 5, 32'h0);
        expect_rd("dump_addr_async_reset", 7, 32'h0);
        expect_rd("x5_cleared", 0, 32'h0);
        expect_rd("rpend_x9_cleared", 4, 32'h0);
        -> chk_ev;
        #1 rst_n = 1'b1;
        tick(); tick(); tick();
        check("no_done_after_reset", 32'(done_cnt - base_done), 32'd0);
        expect_rd("x5_still_cleared", 0, 32'h0);

        // Fresh dump of the cleared file
        for (int i = 0; i < 32; i++) dump_q.push_back('{addr: AW'(i), data: 32'h0});
        base_beats = beats;
        base_done  = done_cnt;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 200 && done_cnt == base_done; c++) tick();
        bus.i_dump_ready = 1'b0;
        check("dump2_beats", 32'(beats - base_beats), 32'd32);
        check("dump2_done_count", 32'(done_cnt - base_done), 32'd1);
        check("dump2_queue_empty", 32'(dump_q.size()), 32'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
